// File: rtl/pipelined_adder_subtractor_if.sv
// Operand/result bundle for pipelined_adder_subtractor (slave = adder side).
// ZF is present only when PIPELINED_ADDER_SUBTRACTOR_ZF_EN is defined.
interface pipelined_adder_subtractor_if #(
  parameter int unsigned DATA_WIDTH = 16
);
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] A;
  logic [DATA_WIDTH-1:0] B;
  logic                  Cin;
  logic                  Sub;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] S;
  logic                  CF;
  logic                  OF;
`ifdef PIPELINED_ADDER_SUBTRACTOR_ZF_EN
  logic                  ZF;

  modport master (
    output in_valid, A, B, Cin, Sub, out_ready,
    input  in_ready, out_valid, S, CF, OF, ZF
  );
  modport slave (
    input  in_valid, A, B, Cin, Sub, out_ready,
    output in_ready, out_valid, S, CF, OF, ZF
  );
`else
  modport master (
    output in_valid, A, B, Cin, Sub, out_ready,
    input  in_ready, out_valid, S, CF, OF
  );
  modport slave (
    input  in_valid, A, B, Cin, Sub, out_ready,
    output in_ready, out_valid, S, CF, OF
  );
`endif
endinterface

// File: rtl/pipelined_adder_subtractor.sv
// Block-pipelined adder/subtractor: one BLOCK_SIZE slice per stage, valid/ready with global stall.
// Defining PIPELINED_ADDER_SUBTRACTOR_ZF_EN adds a registered zero flag (ZF).
module pipelined_adder_subtractor #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned BLOCK_SIZE = 4
) (
  input logic                         clk,
  input logic                         rst_n,
  pipelined_adder_subtractor_if.slave bus
);
  localparam int unsigned NUM_STAGES = DATA_WIDTH / BLOCK_SIZE;
  localparam int unsigned Last       = NUM_STAGES - 1;

  logic out_valid;
  logic advance;

  assign advance      = !out_valid || bus.out_ready;
  assign bus.in_ready = advance;

  for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stage
    // Operand bits still to be added shrink by one block per stage.
    localparam int unsigned SrcW = DATA_WIDTH - k * BLOCK_SIZE;
    localparam int unsigned SumW = (k + 1) * BLOCK_SIZE;

    logic [SrcW-1:0]       a_src;
    logic [SrcW-1:0]       b_src;
    logic                  c_src;
    logic                  sub_src;
    logic                  v_src;
    logic                  sign_a_src;
    logic                  sign_b_src;
    logic [BLOCK_SIZE:0]   blk;
    logic [SumW-1:0]       s_d;
    logic [SumW-1:0]       s_q;
    logic                  c_q;
    logic                  sub_q;
    logic                  v_q;
    logic                  sign_a_q;
    logic                  sign_b_q;

    if (k == 0) begin : g_head
      // Subtraction is A + ~B + 1; Cin is ignored in that mode.
      assign a_src      = bus.A;
      assign b_src      = bus.Sub ? ~bus.B : bus.B;
      assign c_src      = bus.Sub | bus.Cin;
      assign sub_src    = bus.Sub;
      assign v_src      = bus.in_valid;
      assign sign_a_src = bus.A[DATA_WIDTH-1];
      assign sign_b_src = b_src[SrcW-1];
      assign s_d        = blk[BLOCK_SIZE-1:0];
    end else begin : g_body
      assign a_src      = g_stage[k-1].g_ops.a_q;
      assign b_src      = g_stage[k-1].g_ops.b_q;
      assign c_src      = g_stage[k-1].c_q;
      assign sub_src    = g_stage[k-1].sub_q;
      assign v_src      = g_stage[k-1].v_q;
      assign sign_a_src = g_stage[k-1].sign_a_q;
      assign sign_b_src = g_stage[k-1].sign_b_q;
      assign s_d        = {blk[BLOCK_SIZE-1:0], g_stage[k-1].s_q};
    end

    assign blk = {1'b0, a_src[BLOCK_SIZE-1:0]} + {1'b0, b_src[BLOCK_SIZE-1:0]}
               + {{BLOCK_SIZE{1'b0}}, c_src};

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v_q      <= 1'b0;
        s_q      <= '0;
        c_q      <= 1'b0;
        sub_q    <= 1'b0;
        sign_a_q <= 1'b0;
        sign_b_q <= 1'b0;
      end else if (advance) begin
        v_q      <= v_src;
        s_q      <= s_d;
        c_q      <= blk[BLOCK_SIZE];
        sub_q    <= sub_src;
        sign_a_q <= sign_a_src;
        sign_b_q <= sign_b_src;
      end
    end

    if (k < Last) begin : g_ops
      logic [SrcW-BLOCK_SIZE-1:0] a_q;
      logic [SrcW-BLOCK_SIZE-1:0] b_q;

      always_ff @(posedge clk) begin
        if (advance) begin
          a_q <= a_src[SrcW-1:BLOCK_SIZE];
          b_q <= b_src[SrcW-1:BLOCK_SIZE];
        end
      end
    end
  end

  assign out_valid     = g_stage[Last].v_q;
  assign bus.out_valid = out_valid;
  assign bus.S         = g_stage[Last].s_q;
  // In subtract mode the carry out is an inverted borrow.
  assign bus.CF        = g_stage[Last].c_q ^ g_stage[Last].sub_q;
  assign bus.OF        = (g_stage[Last].sign_a_q == g_stage[Last].sign_b_q)
                      && (g_stage[Last].s_q[DATA_WIDTH-1] != g_stage[Last].sign_a_q);

`ifdef PIPELINED_ADDER_SUBTRACTOR_ZF_EN
  logic zf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zf_q <= 1'b0;
    end else if (advance) begin
      zf_q <= ~|g_stage[Last].s_d;
    end
  end

  assign bus.ZF = zf_q;
`endif

endmodule

// File: tb/tb_pipelined_adder_subtractor.sv
// Self-checking bench for pipelined_adder_subtractor: arithmetic reference model, scoreboard
// queue compared every cycle, plus directed vectors, stall, reset and random sweeps.
module tb_pipelined_adder_subtractor;
  localparam int unsigned W  = 16;
  localparam int unsigned NS = 4;

  typedef logic [W+1:0] res_t;  // {S, CF, OF}

  logic clk = 1'b0;
  logic rst_n;

  pipelined_adder_subtractor_if #(.DATA_WIDTH(W)) bus ();

  pipelined_adder_subtractor #(
    .DATA_WIDTH(W),
    .BLOCK_SIZE(4)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int unsigned errors  = 0;
  int unsigned checks  = 0;
  int unsigned popped  = 0;
  res_t        exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Result from integer arithmetic: unsigned range for CF, signed range for OF.
  function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic cin, input logic sub);
    longint ua, ub, sa, sb, us, ss, smax, smin;
    logic [W-1:0] s;
    logic cf, ovf;
    ua   = longint'(a);
    ub   = longint'(b);
    sa   = longint'($signed(a));
    sb   = longint'($signed(b));
    smax = (longint'(1) << (W - 1)) - 1;
    smin = -(longint'(1) << (W - 1));
    if (sub) begin
      us = ua - ub;
      ss = sa - sb;
      cf = (ua < ub);
    end else begin
      us = ua + ub + longint'(cin);
      ss = sa + sb + longint'(cin);
      cf = (us >= (longint'(1) << W));
    end
    s   = W'(us);
    ovf = (ss > smax) || (ss < smin);
    return {s, cf, ovf};
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      check("rst_out_valid", bus.out_valid, 1'b0);
      check("rst_in_ready", bus.in_ready, 1'b1);
      check("rst_result", {bus.S, bus.CF, bus.OF}, '0);
`ifdef PIPELINED_ADDER_SUBTRACTOR_ZF_EN
      check("rst_zf", bus.ZF, 1'b0);
`endif
      exp_q.delete();
    end else begin
      check("in_ready", bus.in_ready, !bus.out_valid || bus.out_ready);
      if (bus.out_valid) begin
        if (exp_q.size() == 0) begin
          check("stale_beat", bus.out_valid, 1'b0);
        end else begin
          check("result", {bus.S, bus.CF, bus.OF}, exp_q[0]);
`ifdef PIPELINED_ADDER_SUBTRACTOR_ZF_EN
          check("zf", bus.ZF, exp_q[0][W+1:2] == '0);
`endif
          if (bus.out_ready) begin
            void'(exp_q.pop_front());
            popped++;
          end
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        exp_q.push_back(model(bus.A, bus.B, bus.Cin, bus.Sub));
      end
    end
  end

  task automatic rand_operands();
    bus.A   = W'($urandom());
    bus.B   = W'($urandom());
    bus.Cin = ($urandom_range(1) == 1);
    bus.Sub = ($urandom_range(1) == 1);
  endtask

  task automatic drain(input string name);
    int g;
    g = 0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    while (exp_q.size() != 0 && g < 40) begin
      @(posedge clk); #1;
      g++;
    end
    check(name, exp_q.size(), 0);
  endtask

  // Single beat into an idle pipeline; latency counted in edges including the accepting one.
  task automatic send_one(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic cin, input logic sub, input res_t exp);
    int edges;
    bus.A = a; bus.B = b; bus.Cin = cin; bus.Sub = sub;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    edges = 1;
    while (!bus.out_valid && edges < 20) begin
      @(posedge clk); #1;
      edges++;
    end
    check({name, "_latency"}, edges, NS);
    check({name, "_result"}, {bus.S, bus.CF, bus.OF}, exp);
`ifdef PIPELINED_ADDER_SUBTRACTOR_ZF_EN
    check({name, "_zf"}, bus.ZF, exp[W+1:2] == '0);
`endif
    @(posedge clk); #1;
  endtask

  task automatic stream_test();
    int sent, c;
    int unsigned p0;
    logic acc;
    sent = 0; c = 0; p0 = popped;
    bus.in_valid = 1'b1;
    rand_operands();
    while (sent < 10 && c < 60) begin
      bus.out_ready = !(c >= 5 && c <= 8);
      @(negedge clk);
      if (c >= 5 && c <= 8) check("stall_in_ready", bus.in_ready, 1'b0);
      acc = bus.in_ready;
      @(posedge clk); #1;
      if (acc) begin
        sent++;
        rand_operands();
      end
      c++;
    end
    check("stream_sent", sent, 10);
    drain("stream_drain");
    check("stream_popped", popped - p0, 10);
  endtask

  task automatic reset_test();
    logic seen;
    bus.out_ready = 1'b1;
    repeat (3) begin
      bus.in_valid = 1'b1;
      rand_operands();
      @(posedge clk); #1;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_pre_valid", bus.out_valid, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_now_out_valid", bus.out_valid, 1'b0);
    check("rst_now_in_ready", bus.in_ready, 1'b1);
    check("rst_now_result", {bus.S, bus.CF, bus.OF}, '0);
    @(posedge clk); @(posedge clk);
    #2 rst_n = 1'b1;
    bus.out_ready = 1'b1;
    seen = 1'b0;
    repeat (8) begin
      @(posedge clk); #1;
      if (bus.out_valid) seen = 1'b1;
    end
    check("rst_no_stale", seen, 1'b0);
    send_one("post_rst_add", 16'hFFFF, 16'h0000, 1'b1, 1'b0, {16'h0000, 1'b1, 1'b0});
  endtask

  task automatic drive_random(input string name, input int n, input int unsigned vpct,
                              input int unsigned rpct);
    int sent, guard;
    logic acc;
    sent = 0; guard = 0;
    bus.in_valid = 1'b0;
    while (sent < n && guard < n * 10 + 100) begin
      if (!bus.in_valid && $urandom_range(99) < vpct) begin
        bus.in_valid = 1'b1;
        rand_operands();
      end
      bus.out_ready = ($urandom_range(99) < rpct);
      @(negedge clk);
      acc = bus.in_valid && bus.in_ready;
      @(posedge clk); #1;
      if (acc) begin
        sent++;
        bus.in_valid = 1'b0;
      end
      guard++;
    end
    check({name, "_sent"}, sent, n);
    drain({name, "_drain"});
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.A         = '0;
    bus.B         = '0;
    bus.Cin       = 1'b0;
    bus.Sub       = 1'b0;
    bus.out_ready = 1'b1;

    check("pin_add_of", model(16'h7FFF, 16'h0001, 1'b0, 1'b0), {16'h8000, 1'b0, 1'b1});
    check("pin_sub_borrow", model(16'h0003, 16'h0005, 1'b0, 1'b1), {16'hFFFE, 1'b1, 1'b0});
    check("pin_sub_of", model(16'h8000, 16'h0001, 1'b0, 1'b1), {16'h7FFF, 1'b0, 1'b1});
    check("pin_add_zero", model(16'hFFFF, 16'h0000, 1'b1, 1'b0), {16'h0000, 1'b1, 1'b0});

    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    send_one("add_of", 16'h7FFF, 16'h0001, 1'b0, 1'b0, {16'h8000, 1'b0, 1'b1});
    send_one("sub_borrow", 16'h0003, 16'h0005, 1'b0, 1'b1, {16'hFFFE, 1'b1, 1'b0});
    send_one("sub_of_cin_ignored", 16'h8000, 16'h0001, 1'b1, 1'b1, {16'h7FFF, 1'b0, 1'b1});
    send_one("add_zero", 16'hFFFF, 16'h0000, 1'b1, 1'b0, {16'h0000, 1'b1, 1'b0});

    stream_test();
    reset_test();
    drive_random("backpressure", 1500, 70, 60);
    drive_random("sweep", 65536, 100, 100);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
